demux_1to2_pipe: RTL and testbench
==================================

Name: demux_1to2_pipe

Overview:
- Registered 1-to-2 demultiplexer. It steers one input word to one of two downstream consumers, chosen by a select bit.
- Sits in the pipelined CPU datapath wherever one producer feeds two alternative consumers, e.g. a result bus routed to one of two stage buffers.
- Each branch has a one-entry output register with a valid/ready handshake. Synchronous flush supports pipeline squash on branch/hazard.
- Per-branch transfer counters are provided for debug and performance monitoring.

Parameters:
- size, 32, data width in bits (must be >= 1)
- cnt_w, 16, width of each transfer counter (must be >= 1)

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-high
- flush_i  input  1  synchronous squash of both output registers
- data_i  input  size  input word
- select_i  input  1  0 routes to branch 0, 1 routes to branch 1
- valid_i  input  1  data_i/select_i valid this cycle
- ready_o  output  1  block accepts the input word this cycle
- data0_o  output  size  branch 0 word
- valid0_o  output  1  branch 0 holds a valid word
- ready0_i  input  1  branch 0 consumer accepts
- data1_o  output  size  branch 1 word
- valid1_o  output  1  branch 1 holds a valid word
- ready1_i  input  1  branch 1 consumer accepts
- count0_o  output  cnt_w  completed branch 0 transfers
- count1_o  output  cnt_w  completed branch 1 transfers

Behaviour:
- Reset (rst_i=1 at a rising edge): valid0_o=0, valid1_o=0, data0_o=0, data1_o=0, count0_o=0, count1_o=0. Reset overrides flush_i and all handshakes. While rst_i=1, ready_o=0.
- Slot k is free when valid_k_o=0, or when valid_k_o=1 and ready_k_i=1 (it drains this cycle).
- ready_o = !rst_i && !flush_i && (slot[select_i] is free). This is combinational from select_i, ready0_i, ready1_i, flush_i, valid0_o and valid1_o.
- Input accept: valid_i && ready_o. On accept, data_i loads into slot[select_i] and that slot's valid is set on the next edge.
- Latency: exactly 1 cycle from accept to the word being visible on data_k_o/valid_k_o.
- Throughput: one word per cycle on a branch whose consumer holds ready_k_i=1.
- The non-selected slot is unaffected by an accept.
- Output handshake: a transfer on branch k completes when valid_k_o && ready_k_i.
  - If that slot is not reloaded in the same cycle, valid_k_o clears on the next edge.
  - Simultaneous drain and load on the same slot: the new word replaces the old one, and valid stays 1.
- While valid_k_o=1 and ready_k_i=0, data_k_o is held stable.
- data_k_o keeps its last value after valid_k_o clears. It is not zeroed except by reset.
- Counters: count_k_o increments by 1 on every completed branch k transfer and wraps from 2^cnt_w-1 to 0. Both branches can complete transfers in the same cycle; each counter increments independently.
- Flush (flush_i=1, rst_i=0): both valids clear on the next edge, and no input is accepted (ready_o=0).
  - A branch transfer that completes in the flush cycle still increments its counter, because the consumer has sampled it.
  - Counters and data registers are not cleared by flush.
- valid_i=1 with ready_o=0: no state change. The upstream must hold data_i/select_i until accepted.
- select_i is sampled only when valid_i=1.
- Mid-operation reset: all pending words are discarded and counters are zeroed, in the same cycle regardless of handshakes.

Decomposition:
- No shared package is needed. Branch indices 0/1 map directly to select_i.
- One sub-module is natural: demux_slot. It holds one output register (data, valid), implements load/drain/flush/reset, and holds its transfer counter. It is instantiated twice.
- The top level computes ready_o and the per-slot load enables from select_i.

Test Plan:
- Reset: assert rst_i 2 cycles with valid_i=1 -> ready_o=0, valid0_o=valid1_o=0, data0_o=data1_o=0, count0_o=count1_o=0.
- Routing: ready0_i=ready1_i=1; send 0x11111111 sel=0, then 0xAAAAAAAA sel=1 on consecutive cycles -> data0_o=0x11111111/valid0_o=1 one cycle after the first, data1_o=0xAAAAAAAA/valid1_o=1 the next cycle; count0_o=1, count1_o=1.
- Backpressure: ready0_i=0; send 0x5 sel=0, then 0x6 sel=0 -> ready_o=0 on the second word, data0_o holds 0x5. Raise ready0_i -> 0x5 transfers, 0x6 is accepted the same cycle and appears next cycle. Meanwhile a sel=1 word is accepted with ready_o=1 while branch 0 is stalled.
- Full throughput: ready0_i=1, stream 8 words sel=0 back-to-back -> ready_o stays 1, valid0_o stays 1 for 8 cycles, count0_o=8.
- Flush: valid0_o=1, valid1_o=1, ready0_i=1, ready1_i=0; assert flush_i with valid_i=1 -> ready_o=0, both valids 0 next cycle, count0_o incremented by 1, count1_o unchanged.
- Wrap: cnt_w=2, complete 5 branch 1 transfers -> count1_o sequence 1,2,3,0,1.

Source files
------------

// File: rtl/demux_1to2_pipe_pkg.sv
// Shared definitions for the registered 1-to-2 demultiplexer.
package demux_1to2_pipe_pkg;
    localparam int DEFAULT_SIZE  = 32;
    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic {
        BR0 = 1'b0,
        BR1 = 1'b1
    } branch_e;
endpackage

// File: rtl/demux_1to2_pipe_if.sv
// Upstream word, two downstream branches and their transfer counters.
interface demux_1to2_pipe_if #(
    parameter int size  = 32,
    parameter int cnt_w = 16
);
    logic [size-1:0]  data_i;
    logic             select_i;
    logic             valid_i;
    logic             ready_o;
    logic [size-1:0]  data0_o;
    logic             valid0_o;
    logic             ready0_i;
    logic [size-1:0]  data1_o;
    logic             valid1_o;
    logic             ready1_i;
    logic [cnt_w-1:0] count0_o;
    logic [cnt_w-1:0] count1_o;

    modport master (
        output data_i, select_i, valid_i, ready0_i, ready1_i,
        input  ready_o, data0_o, valid0_o, data1_o, valid1_o, count0_o, count1_o
    );

    modport slave (
        input  data_i, select_i, valid_i, ready0_i, ready1_i,
        output ready_o, data0_o, valid0_o, data1_o, valid1_o, count0_o, count1_o
    );
endinterface

// File: rtl/demux_slot.sv
// One output register of the demux: load/drain/flush plus its transfer counter.
module demux_slot #(
    parameter int size  = 32,
    parameter int cnt_w = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic [size-1:0]  data_i,
    input  logic             ready_i,
    output logic [size-1:0]  data_o,
    output logic             valid_o,
    output logic             free_o,
    output logic [cnt_w-1:0] count_o
);
    logic [size-1:0]  data_q, data_d;
    logic             valid_q, valid_d;
    logic [cnt_w-1:0] count_q, count_d;
    logic             xfer;

    assign xfer   = valid_q && ready_i;
    assign free_o = !valid_q || ready_i;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q + cnt_w'(xfer);
        // Flush wins over load; the caller never loads during flush anyway.
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign count_o = count_q;
endmodule

// File: rtl/demux_1to2_pipe.sv
// Registered 1-to-2 demux: steers an accepted word into one of two handshaked slots.
module demux_1to2_pipe
    import demux_1to2_pipe_pkg::*;
#(
    parameter int size  = DEFAULT_SIZE,
    parameter int cnt_w = DEFAULT_CNT_W
) (
    input logic               clk_i,
    input logic               rst_i,
    input logic               flush_i,
    demux_1to2_pipe_if.slave  bus
);
    branch_e sel;
    logic    free0, free1;
    logic    accept;
    logic    load0, load1;

    assign sel        = branch_e'(bus.select_i);
    assign bus.ready_o = !rst_i && !flush_i && ((sel == BR1) ? free1 : free0);
    assign accept     = bus.valid_i && bus.ready_o;
    assign load0      = accept && (sel == BR0);
    assign load1      = accept && (sel == BR1);

    demux_slot #(.size(size), .cnt_w(cnt_w)) u_slot0 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .load_i  (load0),
        .data_i  (bus.data_i),
        .ready_i (bus.ready0_i),
        .data_o  (bus.data0_o),
        .valid_o (bus.valid0_o),
        .free_o  (free0),
        .count_o (bus.count0_o)
    );

    demux_slot #(.size(size), .cnt_w(cnt_w)) u_slot1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .load_i  (load1),
        .data_i  (bus.data_i),
        .ready_i (bus.ready1_i),
        .data_o  (bus.data1_o),
        .valid_o (bus.valid1_o),
        .free_o  (free1),
        .count_o (bus.count1_o)
    );
endmodule

// File: tb/tb_demux_1to2_pipe.sv
// Directed bench for demux_1to2_pipe: main instance plus a 2-bit-counter instance for wrap.
module tb_demux_1to2_pipe;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    demux_1to2_pipe_if #(.size(32), .cnt_w(16)) ia ();
    demux_1to2_pipe_if #(.size(32), .cnt_w(2))  ib ();

    demux_1to2_pipe #(.size(32), .cnt_w(16)) dut_a (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (ia.slave)
    );

    demux_1to2_pipe #(.size(32), .cnt_w(2)) dut_b (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (ib.slave)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d);
        ia.valid_i  = v;
        ia.select_i = s;
        ia.data_i   = d;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        drive(1'b1, 1'b0, 32'hDEAD_BEEF);
        ia.ready0_i = 1'b1;
        ia.ready1_i = 1'b1;
        ib.valid_i = 1'b0;
        ib.select_i = 1'b1;
        ib.data_i = '0;
        ib.ready0_i = 1'b1;
        ib.ready1_i = 1'b1;

        // reset held two cycles with valid_i high
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_ready", 32'(ia.ready_o), 32'd0);
            chk("rst_valid0", 32'(ia.valid0_o), 32'd0);
            chk("rst_valid1", 32'(ia.valid1_o), 32'd0);
        end
        chk("rst_data0", ia.data0_o, 32'd0);
        chk("rst_data1", ia.data1_o, 32'd0);
        chk("rst_count0", 32'(ia.count0_o), 32'd0);
        chk("rst_count1", 32'(ia.count1_o), 32'd0);
        chk("rst_b_count1", 32'(ib.count1_o), 32'd0);
        rst = 1'b0;

        // routing
        drive(1'b1, 1'b0, 32'h1111_1111);
        #1 chk("route_ready0", 32'(ia.ready_o), 32'd1);
        step();
        chk("route_data0", ia.data0_o, 32'h1111_1111);
        chk("route_valid0", 32'(ia.valid0_o), 32'd1);
        drive(1'b1, 1'b1, 32'hAAAA_AAAA);
        step();
        chk("route_data1", ia.data1_o, 32'hAAAA_AAAA);
        chk("route_valid1", 32'(ia.valid1_o), 32'd1);
        chk("route_valid0_clr", 32'(ia.valid0_o), 32'd0);
        drive(1'b0, 1'b0, 32'h0);
        step();
        chk("route_count0", 32'(ia.count0_o), 32'd1);
        chk("route_count1", 32'(ia.count1_o), 32'd1);
        chk("route_valid1_clr", 32'(ia.valid1_o), 32'd0);
        chk("route_data1_hold", ia.data1_o, 32'hAAAA_AAAA);

        // backpressure on branch 0
        ia.ready0_i = 1'b0;
        drive(1'b1, 1'b0, 32'h5);
        step();
        chk("bp_data0", ia.data0_o, 32'h5);
        drive(1'b1, 1'b0, 32'h6);
        #1 chk("bp_ready_stall", 32'(ia.ready_o), 32'd0);
        step();
        chk("bp_data0_hold", ia.data0_o, 32'h5);
        chk("bp_valid0_hold", 32'(ia.valid0_o), 32'd1);
        drive(1'b1, 1'b1, 32'h7);
        #1 chk("bp_ready_br1", 32'(ia.ready_o), 32'd1);
        step();
        chk("bp_data1", ia.data1_o, 32'h7);
        drive(1'b1, 1'b0, 32'h6);
        ia.ready0_i = 1'b1;
        #1 chk("bp_ready_drain", 32'(ia.ready_o), 32'd1);
        step();
        chk("bp_data0_new", ia.data0_o, 32'h6);
        chk("bp_valid0_new", 32'(ia.valid0_o), 32'd1);
        chk("bp_count0", 32'(ia.count0_o), 32'd2);
        chk("bp_count1", 32'(ia.count1_o), 32'd2);
        drive(1'b0, 1'b0, 32'h0);
        step();
        chk("bp_count0_final", 32'(ia.count0_o), 32'd3);

        // full throughput on branch 0
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'h100 + 32'(i));
            #1 chk("thr_ready", 32'(ia.ready_o), 32'd1);
            step();
            chk("thr_valid0", 32'(ia.valid0_o), 32'd1);
            chk("thr_data0", ia.data0_o, 32'h100 + 32'(i));
        end
        drive(1'b0, 1'b0, 32'h0);
        step();
        chk("thr_count0", 32'(ia.count0_o), 32'd11);
        chk("thr_valid0_clr", 32'(ia.valid0_o), 32'd0);

        // flush with both slots occupied, only branch 0 draining
        ia.ready0_i = 1'b0;
        ia.ready1_i = 1'b0;
        drive(1'b1, 1'b0, 32'h21);
        step();
        drive(1'b1, 1'b1, 32'h22);
        step();
        chk("fl_pre_valid0", 32'(ia.valid0_o), 32'd1);
        chk("fl_pre_valid1", 32'(ia.valid1_o), 32'd1);
        ia.ready0_i = 1'b1;
        flush = 1'b1;
        drive(1'b1, 1'b0, 32'h23);
        #1 chk("fl_ready", 32'(ia.ready_o), 32'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        chk("fl_valid0", 32'(ia.valid0_o), 32'd0);
        chk("fl_valid1", 32'(ia.valid1_o), 32'd0);
        chk("fl_count0", 32'(ia.count0_o), 32'd12);
        chk("fl_count1", 32'(ia.count1_o), 32'd2);
        chk("fl_data0_kept", ia.data0_o, 32'h21);
        chk("fl_data1_kept", ia.data1_o, 32'h22);

        // mid-operation reset discards pending word
        ia.ready1_i = 1'b0;
        drive(1'b1, 1'b1, 32'h33);
        step();
        chk("mr_valid1_pre", 32'(ia.valid1_o), 32'd1);
        drive(1'b0, 1'b0, 32'h0);
        ia.ready1_i = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_valid1", 32'(ia.valid1_o), 32'd0);
        chk("mr_data1", ia.data1_o, 32'd0);
        chk("mr_count0", 32'(ia.count0_o), 32'd0);
        chk("mr_count1", 32'(ia.count1_o), 32'd0);

        // 2-bit counter wrap on branch 1 of the second instance
        for (int i = 0; i < 6; i++) begin
            ib.valid_i  = (i < 5);
            ib.select_i = 1'b1;
            ib.data_i   = 32'h40 + 32'(i);
            step();
            if (i >= 1) chk("wrap_count1", 32'(ib.count1_o), 32'(i % 4));
        end
        ib.valid_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
